// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry circular store buffer sitting between the MEM
// stage and a single-port data memory. Loads own the memory port; pending
// stores drain one per cycle whenever the port is free.
// Optional feature macro STORE_FWD_EN: a load that hits a pending store is
// answered from the youngest matching entry instead of stalling.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        empty_o,
    output logic [6:0]  mem_op_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    logic [31:0]   r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic          w_is_lw;
    logic          w_is_sw;
    logic          w_hit;
    logic          w_match;
    logic          w_stall;
    logic          w_mem_lw;
    logic          w_drain;
    logic          w_enq;
    logic [31:0]   w_fwd_data;
    logic [PW-1:0] w_idx;

    // Hazard search from oldest to youngest so the last match is the youngest store
    always_comb begin
        w_hit      = 1'b0;
        w_match    = 1'b0;
        w_fwd_data = 32'd0;
        w_idx      = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx      = r_head + PW'(k);
            w_match    = (CW'(k) < r_count) && (r_addr[w_idx] == addr_i);
            w_hit      = w_hit | w_match;
            w_fwd_data = w_match ? r_data[w_idx] : w_fwd_data;
        end
    end

    // Port arbitration: an unstalled load wins the memory port, otherwise drain
    always_comb begin
        w_is_lw  = (op_i == OP_LW);
        w_is_sw  = (op_i == OP_SW);
`ifdef STORE_FWD_EN
        w_stall  = 1'b0;
`else
        w_stall  = w_is_lw & w_hit;
`endif
        w_mem_lw = w_is_lw & ~w_stall;
        w_drain  = (r_count != {CW{1'b0}}) & ~w_mem_lw;
        w_enq    = w_is_sw & ~w_stall;
    end

    // Output mux; stall depends only on state and MEM-stage inputs, never on mem_rdata_i
    always_comb begin
        stall_o     = w_stall;
        empty_o     = (r_count == {CW{1'b0}});
        mem_op_o    = 7'd0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        rdata_o     = 32'd0;
        if (w_mem_lw) begin
            mem_op_o   = OP_LW;
            mem_addr_o = addr_i;
`ifdef STORE_FWD_EN
            rdata_o    = w_hit ? w_fwd_data : mem_rdata_i;
`else
            rdata_o    = mem_rdata_i;
`endif
        end else if (w_drain) begin
            mem_op_o    = OP_SW;
            mem_addr_o  = r_addr[r_head];
            mem_wdata_o = r_data[r_head];
        end else begin
            mem_op_o    = 7'd0;
            mem_addr_o  = 32'd0;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards all pending stores at once
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_drain) begin
                r_head <= r_head + PW'(1);
            end
            if (w_enq) begin
                r_tail <= r_tail + PW'(1);
            end
            case ({w_enq, w_drain})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; validity is tracked by count, so contents need no reset
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_addr[r_tail] <= addr_i;
            r_data[r_tail] <= wdata_i;
        end
    end
endmodule
